// File: rtl/queue_unpack_pkg.sv
// Shared definitions for queue_unpack: FSM state encoding and width helpers.
package queue_unpack_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic int beat_width(input int w, input int k);
        return w / k;
    endfunction

    // A single-beat entry still needs a one-bit counter so the vector is legal.
    function automatic int cnt_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/queue_unpack_perf.sv
// queue_unpack_perf: saturating 32-bit count of cycles where a beat is offered but not accepted.
// Latency: count visible one cycle after the stall cycle; no backpressure (observer only).
module queue_unpack_perf (
    input  logic        clk,
    input  logic        arst,
    input  logic        i_stall,
    output logic [31:0] o_stall_cnt
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_stall && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_stall_cnt = cnt_q;

endmodule

// File: rtl/queue_unpack.sv
// queue_unpack: pops W-bit entries from an upstream queue and emits K beats of W/K bits, LSB beat first.
// Latency 1 cycle head->o_valid; beat held stable while i_ready=0; QUEUE_UNPACK_PERF_EN adds o_stall_cnt.
module queue_unpack
    import queue_unpack_pkg::*;
#(
    parameter int W = 32,
    parameter int K = 4
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic                        i_empty_w,
    input  logic [W-1:0]                i_pop_dat,
    output logic                        o_pop,
    output logic                        o_valid,
    output logic [beat_width(W,K)-1:0]  o_dat,
    output logic                        o_last,
    input  logic                        i_ready
`ifdef QUEUE_UNPACK_PERF_EN
    ,
    output logic [31:0]                 o_stall_cnt
`endif
);

    localparam int BW = beat_width(W, K);
    localparam int CW = cnt_width(K);
    localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  cap_q, cap_d;
    logic          busy;
    logic          accept;

    assign busy    = (state_q == BUSY);
    assign accept  = busy && i_ready;
    assign o_valid = busy;
    assign o_last  = busy && (cnt_q == CNT_LAST);
    assign o_dat   = cap_q[int'(cnt_q)*BW +: BW];

    // Reset gates the pop so the upstream queue never loses an entry into a register being cleared.
    assign o_pop = !arst && !i_empty_w && (!busy || (o_last && i_ready));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        if (o_pop) begin
            state_d = BUSY;
            cnt_d   = '0;
            cap_d   = i_pop_dat;
        end else if (accept) begin
            if (o_last) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

`ifdef QUEUE_UNPACK_PERF_EN
    queue_unpack_perf u_perf (
        .clk         (clk),
        .arst        (arst),
        .i_stall     (busy && !i_ready),
        .o_stall_cnt (o_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_queue_unpack.sv
// Scoreboard bench for queue_unpack: a W=32/K=4 instance and a W=8/K=1 instance fed from bench-side queues.
module tb_queue_unpack;

    typedef struct packed {
        logic [7:0] dat;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    logic        e0, r0, pop0, v0, last0;
    logic [31:0] d0;
    logic [7:0]  q0;
    logic        e1, r1, pop1, v1, last1;
    logic [7:0]  d1;
    logic [7:0]  q1;
`ifdef QUEUE_UNPACK_PERF_EN
    logic [31:0] s0, s1;
`endif

    queue_unpack #(.W(32), .K(4)) u0 (
        .clk(clk), .arst(arst), .i_empty_w(e0), .i_pop_dat(d0), .o_pop(pop0),
        .o_valid(v0), .o_dat(q0), .o_last(last0), .i_ready(r0)
`ifdef QUEUE_UNPACK_PERF_EN
        , .o_stall_cnt(s0)
`endif
    );

    queue_unpack #(.W(8), .K(1)) u1 (
        .clk(clk), .arst(arst), .i_empty_w(e1), .i_pop_dat(d1), .o_pop(pop1),
        .o_valid(v1), .o_dat(q1), .o_last(last1), .i_ready(r1)
`ifdef QUEUE_UNPACK_PERF_EN
        , .o_stall_cnt(s1)
`endif
    );

    int errors = 0;
    int checks = 0;
    int pops0 = 0;
    int pops1 = 0;
    logic [31:0] src0[$];
    logic [7:0]  src1[$];
    beat_t exp0[$];
    beat_t exp1[$];
    beat_t b0, b1;
    logic pn0 = 1'b0;
    logic pn1 = 1'b0;
    logic [7:0] pop_dat0 = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic drive_src();
        e0 = (src0.size() == 0);
        d0 = e0 ? 32'h0 : src0[0];
        e1 = (src1.size() == 0);
        d1 = e1 ? 8'h0 : src1[0];
    endtask

    task automatic push0(input logic [31:0] val);
        src0.push_back(val);
        for (int b = 0; b < 4; b++) begin
            exp0.push_back('{dat: val[b*8 +: 8], last: (b == 3)});
        end
        drive_src();
    endtask

    task automatic push1(input logic [7:0] val);
        src1.push_back(val);
        exp1.push_back('{dat: val, last: 1'b1});
        drive_src();
    endtask

    // Advance one clock; the upstream queue consumes its head if o_pop was seen before the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pn0) void'(src0.pop_front());
        if (pn1) void'(src1.pop_front());
        drive_src();
    endtask

    task automatic drain(input string name, input int exp_cycles);
        int n;
        n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_cycles"}, n, exp_cycles);
    endtask

    // Monitor: pops the scoreboard on every accepted beat, independent of the stimulus thread.
    always @(negedge clk) begin
        pn0 = pop0;
        pn1 = pop1;
        if (!arst) begin
            chk("pop0_while_empty", {31'd0, pop0 & e0}, 32'd0);
            chk("pop1_while_empty", {31'd0, pop1 & e1}, 32'd0);
            if (pop0) begin
                pops0++;
                if (v0) pop_dat0 = q0;
            end
            if (pop1) pops1++;
            if (v0 && r0) begin
                if (exp0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat0_unexpected: got %0h expected no beat", q0);
                end else begin
                    b0 = exp0.pop_front();
                    chk("beat0_dat", q0, b0.dat);
                    chk("beat0_last", last0, b0.last);
                end
            end
            if (v1 && r1) begin
                if (exp1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat1_unexpected: got %0h expected no beat", q1);
                end else begin
                    b1 = exp1.pop_front();
                    chk("beat1_dat", q1, b1.dat);
                    chk("beat1_last", last1, b1.last);
                end
            end
        end
    end

    initial begin
        int p;
        r0 = 1'b1;
        r1 = 1'b1;
        drive_src();

        // Reset state, with an entry already waiting upstream.
        push0(32'hDDCCBBAA);
        #1;
        chk("rst_valid", v0, 0);
        chk("rst_last", last0, 0);
        chk("rst_pop", pop0, 0);
        chk("rst_valid1", v1, 0);
`ifdef QUEUE_UNPACK_PERF_EN
        chk("rst_stall", s0, 0);
`endif
        tick();
        tick();
        chk("rst_hold_pop", pop0, 0);
        arst = 1'b0;
        #1;
        chk("first_pop", pop0, 1);

        // Single entry: four beats LSB first, then idle.
        drain("single", 5);
        chk("single_idle", v0, 0);
        chk("single_pops", pops0, 1);

        // Back-to-back entries: second pop lands on the accept of beat 0x03.
        pop_dat0 = 8'h00;
        p = pops0;
        push0(32'h03020100);
        push0(32'h07060504);
        drain("b2b", 9);
        chk("b2b_pop_beat", pop_dat0, 8'h03);
        chk("b2b_pops", pops0 - p, 2);
        chk("b2b_idle", v0, 0);

        // Backpressure on beat 1 for five cycles with a further entry waiting.
        push0(32'hDDCCBBAA);
        push0(32'h87654321);
        tick();
        tick();
        r0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_dat", q0, 8'hBB);
            chk("bp_last", last0, 0);
            chk("bp_pop", pop0, 0);
            tick();
        end
        chk("bp_dat_end", q0, 8'hBB);
`ifdef QUEUE_UNPACK_PERF_EN
        chk("bp_stall_cnt", s0, 5);
`endif
        r0 = 1'b1;
        pop_dat0 = 8'h00;
        drain("bp", 7);
        chk("bp_pop_beat", pop_dat0, 8'hDD);

        // Reset mid-entry: the rest of the entry is dropped, the next one starts at beat 0.
        push0(32'hDDCCBBAA);
        tick();
        tick();
        tick();
        chk("mid_beat2", q0, 8'hCC);
        arst = 1'b1;
        #1;
        exp0.delete();
        push0(32'h44332211);
        #1;
        chk("mid_rst_valid", v0, 0);
        chk("mid_rst_last", last0, 0);
        chk("mid_rst_pop", pop0, 0);
`ifdef QUEUE_UNPACK_PERF_EN
        chk("mid_rst_stall", s0, 0);
`endif
        tick();
        arst = 1'b0;
        drain("mid", 5);
        chk("mid_idle", v0, 0);

        // Empty queue: nothing moves for 100 cycles.
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i % 10 == 0) begin
                chk("empty_pop", pop0, 0);
                chk("empty_valid", v0, 0);
            end
        end

        // K=1 streaming: 16 entries, one pop and one last beat per cycle.
        p = pops1;
        for (int i = 0; i < 16; i++) begin
            push1(8'(8'h30 + 8'(i * 5)));
        end
        drain("k1", 17);
        chk("k1_pops", pops1 - p, 16);
        chk("k1_idle", v1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
